// File: rtl/fetch_queue.sv
// Instruction fetch front-end: 32-bit fetch, 16-bit halfword queue, 1 issue/cycle.
// Define FETCH_PREDECODE_EN to halt fetch after an issued jump/branch until redirect.
module fetch_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 30
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    output logic              ins_req,
    output logic [ADDR_W-1:0] addr,
    input  logic              ins_res,
    input  logic [31:0]       data,
    input  logic              stall,
    input  logic              pc_en,
    input  logic [ADDR_W:0]   pc,
    output logic [15:0]       ins,
    output logic              ins_en,
    output logic [15:0]       ext,
    output logic              ext_en
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]       mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              outstanding;
    logic              discard;
    logic              skip_low;
    logic              halt;
    logic [ADDR_W-1:0] ip;

    logic [15:0] head;
    logic [15:0] next_h;
    logic        accept;
    logic        load;
    logic        take1;
    logic        take2;
    logic        brk;
    logic [1:0]  n_push;
    logic [1:0]  n_pop;

    assign head   = mem[rd_ptr];
    assign next_h = mem[rd_ptr + PW'(1)];
    assign addr   = ip;

    // A redirect cycle never issues a request so the new target is fetched next cycle
    always_comb begin
        ins_req = !cpu_rst && !outstanding && !halt && !pc_en
                  && (count <= CW'(DEPTH - 2));
        accept  = ins_res && outstanding && !discard && !pc_en;
        load    = !pc_en && (!ins_en || !stall);
        take1   = load && !halt && (count != '0) && !head[15];
        take2   = load && !halt && (count >= CW'(2)) && head[15];
        n_push  = 2'd0;
        if (accept) n_push = skip_low ? 2'd1 : 2'd2;
        n_pop   = 2'd0;
        if (take2)      n_pop = 2'd2;
        else if (take1) n_pop = 2'd1;
`ifdef FETCH_PREDECODE_EN
        brk = (take1 || take2) && (head[14:10] == 5'b11111
                                   || head[14:10] == 5'b11100
                                   || head[14:10] == 5'b11101);
`else
        brk = 1'b0;
`endif
    end

    always_ff @(posedge cpu_clk) begin
        if (accept) begin
            if (skip_low) begin
                mem[wr_ptr] <= data[31:16];
            end else begin
                mem[wr_ptr]          <= data[15:0];
                mem[wr_ptr + PW'(1)] <= data[31:16];
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            skip_low    <= 1'b0;
            halt        <= 1'b0;
            ip          <= '0;
            ins         <= '0;
            ins_en      <= 1'b0;
            ext         <= '0;
            ext_en      <= 1'b0;
        end else if (pc_en) begin
            ip          <= pc[ADDR_W:1];
            skip_low    <= pc[0];
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            ins_en      <= 1'b0;
            ext_en      <= 1'b0;
            halt        <= 1'b0;
            // A response in this same cycle is the one in flight; it is simply dropped
            discard     <= outstanding && !ins_res;
            outstanding <= outstanding && !ins_res;
        end else begin
            rd_ptr <= rd_ptr + PW'(n_pop);
            wr_ptr <= wr_ptr + PW'(n_push);
            count  <= count + CW'(n_push) - CW'(n_pop);
            if (ins_req) begin
                outstanding <= 1'b1;
                ip          <= ip + ADDR_W'(1);
            end
            if (ins_res && outstanding) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
                if (accept) skip_low <= 1'b0;
            end
            if (load) begin
                if (take1 || take2) begin
                    ins    <= head;
                    ins_en <= 1'b1;
                    ext_en <= take2;
                    if (take2) ext <= next_h;
                end else begin
                    ins_en <= 1'b0;
                    ext_en <= 1'b0;
                end
            end
            if (brk) halt <= 1'b1;
        end
    end
endmodule
